// File: rtl/ir_pkg.sv
// Colour codes, sequencer state encoding and the per-colour carrier/burst timing table
// shared by the IR packet sequencer and its carrier generator.
package ir_pkg;

   localparam logic [3:0] COLOUR_BLUE     = 4'b1000;
   localparam logic [3:0] COLOUR_YELLOW   = 4'b1001;
   localparam logic [3:0] COLOUR_GREEN    = 4'b1010;
   localparam logic [3:0] COLOUR_RED      = 4'b1011;
   localparam logic [3:0] COLOUR_NOCOLOUR = 4'b1100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_GAP,
      ST_SELECT,
      ST_BIT,
      ST_FINISH
   } state_t;

   // Half-period in clock cycles, all other fields in carrier periods.
   typedef struct packed {
      logic [10:0] half;
      logic [7:0]  start;
      logic [7:0]  gap;
      logic [7:0]  select;
      logic [7:0]  bit_on;
      logic [7:0]  bit_off;
   } timing_t;

   function automatic logic colour_valid(input logic [3:0] colour);
      return colour[3:2] == 2'b10;
   endfunction

   function automatic timing_t colour_timing(input logic [3:0] colour);
      timing_t t;
      case (colour)
         COLOUR_YELLOW: t = '{half: 11'd1250, start: 8'd88,  gap: 8'd40, select: 8'd22,
                              bit_on: 8'd44, bit_off: 8'd22};
         COLOUR_GREEN:  t = '{half: 11'd1333, start: 8'd88,  gap: 8'd40, select: 8'd44,
                              bit_on: 8'd44, bit_off: 8'd22};
         COLOUR_RED:    t = '{half: 11'd1389, start: 8'd192, gap: 8'd24, select: 8'd24,
                              bit_on: 8'd48, bit_off: 8'd24};
         default:       t = '{half: 11'd1389, start: 8'd191, gap: 8'd25, select: 8'd47,
                              bit_on: 8'd47, bit_off: 8'd22};
      endcase
      return t;
   endfunction

endpackage

// File: rtl/ir_packet_sequencer_if.sv
// Request/status bundle between the trigger chain and the IR packet sequencer.
interface ir_packet_sequencer_if;

   logic       SEND;
   logic [3:0] COLOUR;
   logic [3:0] COMMAND;
   logic       IR_LED;
   logic       BUSY;
   logic       DONE;

   modport master (
      output SEND, COLOUR, COMMAND,
      input  IR_LED, BUSY, DONE
   );

   modport slave (
      input  SEND, COLOUR, COMMAND,
      output IR_LED, BUSY, DONE
   );

endinterface

// File: rtl/ir_carrier_gen.sv
// Square-wave carrier: high for the first half of each period, low for the second,
// with a pulse on the last cycle of every period.
module ir_carrier_gen #(
   parameter int unsigned HALF_CNT_WIDTH = 11
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic [HALF_CNT_WIDTH-1:0] half,
   output logic                      carrier,
   output logic                      period_end
);

   logic [HALF_CNT_WIDTH-1:0] half_cnt;
   logic [HALF_CNT_WIDTH-1:0] half_last;
   logic                      phase;
   logic                      half_end;

   assign half_last = half - HALF_CNT_WIDTH'(1);
   assign half_end  = (half_cnt == half_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         half_cnt <= '0;
         phase    <= 1'b0;
      end else if (clear) begin
         half_cnt <= '0;
         phase    <= 1'b0;
      end else if (half_end) begin
         half_cnt <= '0;
         phase    <= ~phase;
      end else begin
         half_cnt <= half_cnt + HALF_CNT_WIDTH'(1);
      end
   end

   assign carrier    = ~phase;
   assign period_end = phase & half_end;

endmodule

// File: rtl/ir_packet_sequencer.sv
// Sends one IR car-control packet (start, select, four command bits, each followed by a gap)
// on every accepted SEND, gating the colour-specific carrier onto IR_LED during bursts.
module ir_packet_sequencer
   import ir_pkg::*;
#(
   parameter int unsigned PERIOD_CNT_WIDTH = 8,
   parameter int unsigned HALF_CNT_WIDTH   = 11,
   parameter int unsigned HALF_OVERRIDE    = 0
) (
   input logic                  CLK,
   input logic                  RESET,
   ir_packet_sequencer_if.slave bus
);

   state_t                      state;
   state_t                      state_next;
   logic [3:0]                  colour_q;
   logic [3:0]                  command_q;
   logic [2:0]                  step;
   logic [1:0]                  bit_idx;
   logic [PERIOD_CNT_WIDTH-1:0] period_cnt;
   logic [PERIOD_CNT_WIDTH-1:0] seg_len;
   logic [HALF_CNT_WIDTH-1:0]   half;
   timing_t                     timing;
   logic                        carrier;
   logic                        period_end;
   logic                        seg_done;
   logic                        accept;
   logic                        clear;

   assign timing = colour_timing(colour_q);
   assign half   = (HALF_OVERRIDE != 0) ? HALF_CNT_WIDTH'(HALF_OVERRIDE)
                                        : HALF_CNT_WIDTH'(timing.half);
   assign accept = (state == ST_IDLE) && bus.SEND && colour_valid(bus.COLOUR);
   assign clear  = (state == ST_IDLE) || (state == ST_FINISH);

   // step counts completed gaps; bursts after gaps 2..5 carry command bits 3..0.
   assign bit_idx = 2'(3'd5 - step);

   ir_carrier_gen #(
      .HALF_CNT_WIDTH(HALF_CNT_WIDTH)
   ) u_carrier (
      .clk       (CLK),
      .rst       (RESET),
      .clear     (clear),
      .half      (half),
      .carrier   (carrier),
      .period_end(period_end)
   );

   always_comb begin
      seg_len = '0;
      case (state)
         ST_START:  seg_len = PERIOD_CNT_WIDTH'(timing.start);
         ST_GAP:    seg_len = PERIOD_CNT_WIDTH'(timing.gap);
         ST_SELECT: seg_len = PERIOD_CNT_WIDTH'(timing.select);
         ST_BIT:    seg_len = command_q[bit_idx] ? PERIOD_CNT_WIDTH'(timing.bit_on)
                                                 : PERIOD_CNT_WIDTH'(timing.bit_off);
         default:   seg_len = '0;
      endcase
   end

   assign seg_done = period_end && (period_cnt == seg_len - PERIOD_CNT_WIDTH'(1));

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= ST_IDLE;
         colour_q   <= '0;
         command_q  <= '0;
         step       <= '0;
         period_cnt <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            colour_q   <= bus.COLOUR;
            command_q  <= bus.COMMAND;
            step       <= '0;
            period_cnt <= '0;
         end else if (seg_done) begin
            period_cnt <= '0;
            if (state == ST_GAP)
               step <= step + 3'd1;
         end else if (period_end) begin
            period_cnt <= period_cnt + PERIOD_CNT_WIDTH'(1);
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:
            if (accept) state_next = ST_START;
         ST_START, ST_SELECT, ST_BIT:
            if (seg_done) state_next = ST_GAP;
         ST_GAP:
            if (seg_done) begin
               if (step == 3'd0)      state_next = ST_SELECT;
               else if (step == 3'd5) state_next = ST_FINISH;
               else                   state_next = ST_BIT;
            end
         ST_FINISH:
            state_next = ST_IDLE;
         default:
            state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.IR_LED = 1'b0;
      bus.BUSY   = 1'b0;
      bus.DONE   = 1'b0;
      case (state)
         ST_START, ST_SELECT, ST_BIT: begin
            bus.IR_LED = carrier;
            bus.BUSY   = 1'b1;
         end
         ST_GAP:
            bus.BUSY = 1'b1;
         ST_FINISH: begin
            bus.BUSY = 1'b1;
            bus.DONE = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
